ifu: RTL and testbench
======================

// Module: ifu
// PURPOSE
//   F-stage instruction fetch unit: producer of the F_instr/F_pc pair captured by the
//   F->D pipeline register. Holds the PC and runs a one-outstanding-request handshake
//   to instruction memory. Buffers an instruction that returns while the pipe is
//   stalled, and applies D-stage branch/jump redirects after the delay slot.
//   Sits between IM and the F->D register; its f_stall is OR'd into the hazard stall.
// PARAMETERS
//   PC_RESET  32'h0000_3000  PC value loaded on reset (first fetch address)
// PORTS
//   clk            in   1   clock; all state updates on posedge
//   reset          in   1   synchronous, active-high reset
//   stall          in   1   hazard-unit stall excluding fetch; F->D en = !(stall|f_stall)
//   redirect_valid in   1   D-stage branch taken / jump; sampled only on advance cycles
//   redirect_pc    in   32  D-stage target; bits [1:0] ignored, treated as 0
//   imem_req       out  1   request to IM; held high until imem_ack
//   imem_addr      out  32  word address of request = current PC; stable while imem_req
//   imem_rdata     in   32  instruction word; valid only when imem_ack=1
//   imem_ack       in   1   response strobe; may arrive same cycle as imem_req or later
//   F_instr        out  32  fetched instruction; 32'h0 (nop) whenever F_valid=0
//   F_pc           out  32  PC of F_instr (= PC register)
//   F_valid        out  1   F_instr holds a real fetched instruction
//   f_stall        out  1   = !F_valid; stalls F->D capture and older-stage advance
// BEHAVIOUR
//   Reset: synchronous, active-high. pc<=PC_RESET, state<=REQ, hold_buf<=0.
//     Outputs after reset: imem_req=1, imem_addr=PC_RESET, F_pc=PC_RESET,
//     F_instr=0, F_valid=0 (unless imem_ack that cycle), f_stall=!F_valid.
//     imem_ack in a reset cycle is ignored. Reset mid-request abandons it.
//   States: REQ (request outstanding), HOLD (instruction buffered, no request).
//   REQ:  imem_req=1, imem_addr=pc; F_valid=imem_ack; F_instr=imem_ack?imem_rdata:0
//         (combinational pass-through, 0-cycle latency from ack).
//     ack & !stall   -> advance: pc<=next_pc; stay REQ (new request next cycle).
//     ack &  stall   -> hold_buf<=imem_rdata; go HOLD.
//     !ack           -> stay REQ; pc, imem_addr unchanged.
//   HOLD: imem_req=0; F_valid=1; F_instr=hold_buf.
//     !stall -> advance: pc<=next_pc; go REQ.   stall -> stay HOLD, all state held.
//   advance = F_valid & !stall (the cycle the F->D register captures F_instr/F_pc).
//   next_pc = (advance & redirect_valid) ? {redirect_pc[31:2],2'b00} : pc+32'd4.
//     Delay-slot rule: the instruction captured in the redirect cycle is the delay slot;
//     the target is the fetch after it. redirect_valid in non-advance cycles ignored
//     (branch still in D re-asserts it). pc+4 wraps modulo 2^32 (FFFF_FFFC -> 0000_0000).
//   Simultaneous stall + ack: buffered, never dropped or duplicated.
//   Exactly one IM request per delivered instruction; no request while HOLD.
//   F_pc constant between advances; changes only on the cycle after an advance.
//   Throughput: 1 instr/cycle with 0-wait IM and no stalls.
// TESTING
//   1. Reset, IM acks same cycle, stall=0 for 4 cycles -> F_pc 3000,3004,3008,300C;
//      F_instr = IM[pc]; f_stall=0 every cycle.
//   2. IM ack delayed 3 cycles at pc=3004 -> imem_addr=3004 held 3 cycles, F_instr=0,
//      f_stall=1 until ack; then advances to 3008; exactly one request for 3004.
//   3. Ack with stall=1 for 2 cycles (data 0x24080005) -> HOLD, imem_req=0,
//      F_instr=0x24080005 held; stall drops -> advance once, next request pc+4.
//   4. Advance at pc=3010 with redirect_valid=1, redirect_pc=3040 -> delay slot 3010
//      captured, next F_pc=3040; redirect while stalled -> ignored, pc unchanged.
//   5. pc=FFFF_FFFC advance, no redirect -> F_pc=0000_0000; redirect_pc=3043 -> 3040.
//   6. Reset asserted while in REQ waiting / in HOLD -> next cycle pc=3000, state REQ,
//      hold_buf discarded; ack during reset cycle ignored.

Source files
------------

// File: rtl/ifu.sv
// Instruction fetch unit: owns the PC, keeps one request outstanding to instruction
// memory, buffers a word that returns during a stall, and applies delay-slot redirects.
module ifu #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic [31:0] F_instr,
    output logic [31:0] F_pc,
    output logic        F_valid,
    output logic        f_stall
);

    typedef enum logic {
        S_REQ  = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] hold_buf_reg, hold_buf_next;
    logic        advance;
    logic [1:0]  unused_redirect_lsb;

    assign unused_redirect_lsb = redirect_pc[1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= S_REQ;
            pc_reg       <= PC_RESET;
            hold_buf_reg <= 32'h0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            hold_buf_reg <= hold_buf_next;
        end
    end

    always_comb begin
        imem_req      = 1'b0;
        imem_addr     = pc_reg;
        F_pc          = pc_reg;
        F_valid       = 1'b0;
        F_instr       = 32'h0;
        state_next    = state_reg;
        hold_buf_next = hold_buf_reg;

        case (state_reg)
            S_REQ: begin
                imem_req = 1'b1;
                F_valid  = imem_ack;
                F_instr  = imem_ack ? imem_rdata : 32'h0;
                // A word returning during a stall must be kept, the request is already spent.
                if (imem_ack && stall) begin
                    hold_buf_next = imem_rdata;
                    state_next    = S_HOLD;
                end
            end
            S_HOLD: begin
                F_valid = 1'b1;
                F_instr = hold_buf_reg;
                if (!stall) begin
                    state_next = S_REQ;
                end
            end
            default: state_next = S_REQ;
        endcase

        advance = F_valid && !stall;
        f_stall = !F_valid;

        // Redirect targets the fetch after the delay slot being captured this cycle.
        pc_next = pc_reg;
        if (advance) begin
            pc_next = redirect_valid ? {redirect_pc[31:2], 2'b00} : pc_reg + 32'd4;
        end
    end

endmodule

// File: tb/tb_ifu.sv
// Self-checking bench for ifu: directed scenarios followed by random stall/ack/redirect
// traffic, compared each cycle against a fetch-level reference model.
module tb_ifu;

    localparam logic [31:0] PC_RESET = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ack;
    logic [31:0] F_instr;
    logic [31:0] F_pc;
    logic        F_valid;
    logic        f_stall;

    int errors = 0;
    int checks = 0;

    // Reference model: the address being fetched and whether a word is parked.
    logic [31:0] m_pc   = PC_RESET;
    bit          m_held = 1'b0;
    logic [31:0] m_buf  = 32'h0;
    int          m_delivered = 0;

    ifu #(.PC_RESET(PC_RESET)) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .imem_ack      (imem_ack),
        .F_instr       (F_instr),
        .F_pc          (F_pc),
        .F_valid       (F_valid),
        .f_stall       (f_stall)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] im_word(input logic [31:0] addr);
        return {addr[15:0] ^ 16'h5A5A, addr[31:16] ^ 16'h0F0F};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs against the model, then let the edge happen.
    task automatic cyc(input logic r, input logic st, input logic ak, input logic rv,
                       input logic [31:0] rpc, input logic [31:0] rd, input bit chk);
        bit          e_valid;
        logic [31:0] e_instr;
        reset          = r;
        stall          = st;
        imem_ack       = ak;
        redirect_valid = rv;
        redirect_pc    = rpc;
        imem_rdata     = ak ? rd : 32'hDEAD_BEEF;
        #1;
        e_valid = m_held || ak;
        e_instr = m_held ? m_buf : (ak ? rd : 32'h0);
        if (chk) begin
            check("imem_req",  {31'h0, imem_req}, {31'h0, !m_held});
            if (!m_held) check("imem_addr", imem_addr, m_pc);
            check("F_pc",      F_pc, m_pc);
            check("F_valid",   {31'h0, F_valid}, {31'h0, e_valid});
            check("F_instr",   F_instr, e_instr);
            check("f_stall",   {31'h0, f_stall}, {31'h0, !e_valid});
        end
        $display("cyc rst=%0b stall=%0b ack=%0b rv=%0b rpc=%h | req=%0b addr=%h F_pc=%h F_valid=%0b F_instr=%h",
                 r, st, ak, rv, rpc, imem_req, imem_addr, F_pc, F_valid, F_instr);
        if (r) begin
            m_pc   = PC_RESET;
            m_held = 1'b0;
        end else if (e_valid && !st) begin
            m_pc   = rv ? {rpc[31:2], 2'b00} : m_pc + 32'd4;
            m_held = 1'b0;
            m_delivered++;
        end else if (!m_held && ak && st) begin
            m_held = 1'b1;
            m_buf  = rd;
        end
        @(posedge clk);
        #2;
    endtask

    task automatic adv();
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, im_word(m_pc), 1'b1);
    endtask

    task automatic do_reset(input logic ak);
        cyc(1'b1, 1'b0, ak, 1'b0, 32'h0, 32'h1234_5678, 1'b0);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; imem_ack = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'h0; imem_rdata = 32'h0;
        @(posedge clk);
        #2;

        // 1: reset (ack during reset ignored), then zero-wait streaming
        do_reset(1'b1);
        check("reset_pc", F_pc, 32'h0000_3000);
        repeat (4) adv();
        check("stream_pc", F_pc, 32'h0000_3010);

        // 2: ack delayed three cycles at 3004
        do_reset(1'b0);
        adv();
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        adv();
        check("delay_pc", F_pc, 32'h0000_3008);

        // 3: ack under stall gets parked, released once
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h2408_0005, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        check("hold_instr", F_instr, 32'h2408_0005);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        check("hold_next_pc", F_pc, 32'h0000_300C);
        adv();

        // 4: redirect with delay slot at 3010; redirect while stalled ignored
        do_reset(1'b0);
        repeat (4) adv();
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_3040, im_word(m_pc), 1'b1);
        check("redir_pc", F_pc, 32'h0000_3040);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_5000, im_word(m_pc), 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_5000, 32'h0, 1'b1);
        check("stall_redir_pc", F_pc, 32'h0000_3040);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

        // 5: wrap at top of address space, and target low bits cleared
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, im_word(m_pc), 1'b1);
        check("top_pc", F_pc, 32'hFFFF_FFFC);
        adv();
        check("wrap_pc", F_pc, 32'h0000_0000);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_3043, im_word(m_pc), 1'b1);
        check("align_pc", F_pc, 32'h0000_3040);

        // 6: reset while waiting in REQ and while holding
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h7777_7777, 1'b1);
        check("rst_req_pc", F_pc, 32'h0000_3000);
        adv();
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'hABCD_0001, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        check("rst_hold_req", {31'h0, imem_req}, 32'h1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic r, st, ak, rv;
            logic [31:0] rpc;
            r   = ($urandom_range(0, 49) == 0);
            st  = ($urandom_range(0, 2) == 0);
            ak  = ($urandom_range(0, 1) == 0);
            rv  = ($urandom_range(0, 4) == 0);
            rpc = $urandom;
            cyc(r, st, ak, rv, rpc, im_word(m_pc) ^ i, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
